// File: rtl/project_select_ctrl_if.sv
// Wishbone slave-side bundle for the project select register.
// The master drives the request signals; the slave returns ack and read data.
interface project_select_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        cfg_ack_o;
    logic [31:0] cfg_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  cfg_ack_o, cfg_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output cfg_ack_o, cfg_dat_o
    );
endinterface

// File: rtl/project_select_ctrl.sv
// Wishbone-programmable project selector with drain and reset-hold sequencing.
// Optional macro PIN_OVERRIDE_EN lets pin_override_i/pin_cfg_i request switches.
module project_select_ctrl #(
    parameter int          USER_PROJECTS = 4,
    parameter int          CFG_BITS      = 2,
    parameter logic [31:0] CFG_ADDRESS   = 32'h300F_FFFC,
    parameter int          RST_CYCLES    = 16,
    parameter int          DRAIN_TIMEOUT = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    project_select_ctrl_if.slave     wbs,
    input  logic                     proj_ack_i,
    output logic [CFG_BITS-1:0]      configuration,
    output logic [USER_PROJECTS-1:0] proj_rst_o,
    output logic                     busy_o,
    input  logic                     pin_override_i,
    input  logic [CFG_BITS-1:0]      pin_cfg_i
);

    localparam int CNT_MAX = (RST_CYCLES > DRAIN_TIMEOUT) ? RST_CYCLES : DRAIN_TIMEOUT;
    localparam int CNT_W   = ($clog2(CNT_MAX + 1) > 8) ? $clog2(CNT_MAX + 1) : 8;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HOLD
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [CFG_BITS-1:0] pending;
    logic                err;

    logic                cfg_access;
    logic                wr_access;
    logic [CFG_BITS-1:0] wr_cfg;
    logic                wr_in_range;
    logic                wr_open;
    logic                wr_switch;
    logic                wr_same;
    logic                in_flight;
    logic                pin_block;
    logic                pin_switch;
    logic                start_switch;
    logic [CFG_BITS-1:0] next_cfg;

    assign cfg_access = wbs.wbs_cyc_i & wbs.wbs_stb_i & (wbs.wbs_adr_i == CFG_ADDRESS)
                        & ~wbs.cfg_ack_o;
    assign wr_access  = cfg_access & wbs.wbs_we_i & wbs.wbs_sel_i[0];
    assign wr_cfg     = wbs.wbs_dat_i[CFG_BITS-1:0];

    // The whole word is range-checked so a value like 7 is rejected rather
    // than silently aliasing onto a valid index through its low bits.
    assign wr_in_range = wbs.wbs_dat_i < 32'(USER_PROJECTS);

    assign wr_open   = (state == RUN) & ~pin_block;
    assign wr_switch = wr_access & wr_open & wr_in_range & (wr_cfg != configuration);
    assign wr_same   = wr_access & wr_open & wr_in_range & (wr_cfg == configuration);

    assign in_flight = wbs.wbs_cyc_i & wbs.wbs_stb_i & (wbs.wbs_adr_i != CFG_ADDRESS)
                       & ~proj_ack_i;

`ifdef PIN_OVERRIDE_EN
    assign pin_block  = pin_override_i;
    assign pin_switch = (state == RUN) & pin_override_i
                        & ({{(32-CFG_BITS){1'b0}}, pin_cfg_i} < 32'(USER_PROJECTS))
                        & (pin_cfg_i != configuration);
`else
    logic unused_pin;
    assign unused_pin = ^{pin_override_i, pin_cfg_i};
    assign pin_block  = 1'b0;
    assign pin_switch = 1'b0;
`endif

    logic unused_sel;
    assign unused_sel = ^wbs.wbs_sel_i[3:1];

    assign start_switch = pin_switch | wr_switch;
    assign next_cfg     = pin_switch ? pin_cfg_i : wr_cfg;
    assign busy_o       = (state != RUN);

    always_comb begin
        // NOTE: default assignment first so every path drives the output and no latch is inferred.
        proj_rst_o = '1;
        for (int k = 0; k < USER_PROJECTS; k++) begin
            proj_rst_o[k] = (configuration != CFG_BITS'(k)) || (state == HOLD);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state         <= HOLD;
            cnt           <= '0;
            configuration <= '0;
            pending       <= '0;
            err           <= 1'b0;
            wbs.cfg_ack_o <= 1'b0;
            wbs.cfg_dat_o <= '0;
        end else begin
            wbs.cfg_ack_o <= cfg_access;
            if (cfg_access) begin
                wbs.cfg_dat_o <= {busy_o, err, {(30-CFG_BITS){1'b0}}, configuration};
            end

            // Rejected writes (busy, out of range, pin override) still get acked.
            if (wr_access) begin
                err <= ~(wr_switch | wr_same);
            end

            case (state)
                RUN: begin
                    if (start_switch) begin
                        pending <= next_cfg;
                        cnt     <= '0;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!in_flight || cnt == CNT_W'(DRAIN_TIMEOUT - 1)) begin
                        configuration <= pending;
                        cnt           <= '0;
                        state         <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_project_select_ctrl.sv
// Directed bench for project_select_ctrl; a second instance with a short
// drain timeout shadows the same bus to exercise the timeout exit.
module tb_project_select_ctrl;

    localparam logic [31:0] CFG_ADDR  = 32'h300F_FFFC;
    localparam logic [31:0] PROJ_ADDR = 32'h3000_0010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    project_select_ctrl_if wb ();
    project_select_ctrl_if wbt ();

    assign wbt.wbs_stb_i = wb.wbs_stb_i;
    assign wbt.wbs_cyc_i = wb.wbs_cyc_i;
    assign wbt.wbs_we_i  = wb.wbs_we_i;
    assign wbt.wbs_sel_i = wb.wbs_sel_i;
    assign wbt.wbs_dat_i = wb.wbs_dat_i;
    assign wbt.wbs_adr_i = wb.wbs_adr_i;

    logic       proj_ack;
    logic       pin_override;
    logic [1:0] pin_cfg;
    logic [1:0] cfg;
    logic [3:0] proj_rst;
    logic       busy;
    logic [1:0] cfg_to;
    logic [3:0] proj_rst_to;
    logic       busy_to;

    project_select_ctrl u_dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .wbs            (wb),
        .proj_ack_i     (proj_ack),
        .configuration  (cfg),
        .proj_rst_o     (proj_rst),
        .busy_o         (busy),
        .pin_override_i (pin_override),
        .pin_cfg_i      (pin_cfg)
    );

    project_select_ctrl #(.DRAIN_TIMEOUT(4)) u_dut_to (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .wbs            (wbt),
        .proj_ack_i     (proj_ack),
        .configuration  (cfg_to),
        .proj_rst_o     (proj_rst_to),
        .busy_o         (busy_to),
        .pin_override_i (pin_override),
        .pin_cfg_i      (pin_cfg)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'h0;
        wb.wbs_dat_i = '0;
        wb.wbs_adr_i = '0;
    endtask

    // Single config access; returns one cycle after the ack with the bus idle.
    task automatic wb_access(input logic we, input logic [31:0] dat, output logic [31:0] rdata);
        int waited = 0;
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = we;
        wb.wbs_sel_i = 4'hF;
        wb.wbs_dat_i = dat;
        wb.wbs_adr_i = CFG_ADDR;
        @(negedge clk);
        while (wb.cfg_ack_o !== 1'b1 && waited < 4) begin
            waited++;
            @(negedge clk);
        end
        check("ack_latency", 32'(waited), 32'd0);
        rdata = wb.cfg_dat_o;
        bus_idle();
        @(negedge clk);
        check("ack_drop", 32'(wb.cfg_ack_o), 32'd0);
    endtask

    // Called on the cycle reset is released: 16 cycles of full reset, then project 0 runs.
    task automatic hold_release(input string tag);
        for (int i = 0; i < 16; i++) begin
            check({tag, "_hold_rst"}, 32'(proj_rst), 32'hF);
            check({tag, "_hold_busy"}, 32'(busy), 32'd1);
            @(negedge clk);
        end
        check({tag, "_run_rst"}, 32'(proj_rst), 32'hE);
        check({tag, "_run_busy"}, 32'(busy), 32'd0);
        check({tag, "_run_cfg"}, 32'(cfg), 32'd0);
    endtask

    task automatic wait_run(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            n++;
            @(negedge clk);
        end
        check("run_reached", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        bus_idle();
        proj_ack     = 1'b0;
        pin_override = 1'b0;
        pin_cfg      = 2'd0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_proj_rst", 32'(proj_rst), 32'hF);
        check("rst_cfg", 32'(cfg), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_ack", 32'(wb.cfg_ack_o), 32'd0);
        check("rst_dat", wb.cfg_dat_o, 32'd0);

        rst = 1'b0;
        hold_release("por");

        // Write 2 with an idle bus: new config two cycles after the write, 16 HOLD cycles.
        wb_access(1'b1, 32'd2, rd);
        check("sw2_cfg", 32'(cfg), 32'd2);
        for (int i = 0; i < 15; i++) begin
            check("sw2_hold", 32'(proj_rst), 32'hF);
            @(negedge clk);
        end
        check("sw2_hold_last", 32'(proj_rst), 32'hF);
        @(negedge clk);
        check("sw2_run_rst", 32'(proj_rst), 32'hB);
        check("sw2_run_busy", 32'(busy), 32'd0);

        wb_access(1'b0, 32'd0, rd);
        check("sw2_readback", rd, 32'h0000_0002);

        // A strobe held across cycles is acked only every other cycle.
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_adr_i = CFG_ADDR;
        @(negedge clk);
        check("held_ack_1", 32'(wb.cfg_ack_o), 32'd1);
        @(negedge clk);
        check("held_ack_2", 32'(wb.cfg_ack_o), 32'd0);
        @(negedge clk);
        check("held_ack_3", 32'(wb.cfg_ack_o), 32'd1);
        bus_idle();
        @(negedge clk);

        // Write 1, then keep a project access unacked for 10 cycles.
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = 1'b1;
        wb.wbs_sel_i = 4'hF;
        wb.wbs_dat_i = 32'd1;
        wb.wbs_adr_i = CFG_ADDR;
        @(negedge clk);
        check("drain_ack", 32'(wb.cfg_ack_o), 32'd1);
        check("drain_busy", 32'(busy), 32'd1);
        wb.wbs_we_i  = 1'b0;
        wb.wbs_dat_i = '0;
        wb.wbs_adr_i = PROJ_ADDR;
        proj_ack     = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check("drain_cfg_held", 32'(cfg), 32'd2);
            if (i < 4) check("timeout_cfg_old", 32'(cfg_to), 32'd2);
            else       check("timeout_cfg_new", 32'(cfg_to), 32'd1);
        end
        proj_ack = 1'b1;
        @(negedge clk);
        check("drain_cfg_new", 32'(cfg), 32'd1);
        check("drain_proj_rst", 32'(proj_rst), 32'hF);
        bus_idle();
        proj_ack = 1'b0;
        wait_run(40);
        check("drain_run_rst", 32'(proj_rst), 32'hD);
        check("timeout_run_busy", 32'(busy_to), 32'd0);

        // Out-of-range write sets err without switching.
        wb_access(1'b1, 32'd7, rd);
        check("oor_busy", 32'(busy), 32'd0);
        check("oor_cfg", 32'(cfg), 32'd1);
        wb_access(1'b0, 32'd0, rd);
        check("oor_readback", rd, 32'h4000_0001);

        // Valid write clears err; a write during HOLD is rejected.
        wb_access(1'b1, 32'd3, rd);
        check("sw3_cfg", 32'(cfg), 32'd3);
        wb_access(1'b0, 32'd0, rd);
        check("sw3_readback", rd, 32'h8000_0003);
        wb_access(1'b1, 32'd2, rd);
        check("busy_wr_cfg", 32'(cfg), 32'd3);
        wb_access(1'b0, 32'd0, rd);
        check("busy_wr_readback", rd, 32'hC000_0003);

        // Reset pulse mid-HOLD aborts to project 0 with a full HOLD.
        rst = 1'b1;
        @(negedge clk);
        check("abort_cfg", 32'(cfg), 32'd0);
        check("abort_proj_rst", 32'(proj_rst), 32'hF);
        rst = 1'b0;
        hold_release("abort");
        wb_access(1'b0, 32'd0, rd);
        check("abort_readback", rd, 32'h0000_0000);

        pin_override = 1'b1;
        pin_cfg      = 2'd3;
`ifdef PIN_OVERRIDE_EN
        @(negedge clk);
        check("pin_busy", 32'(busy), 32'd1);
        wait_run(40);
        check("pin_cfg", 32'(cfg), 32'd3);
        check("pin_proj_rst", 32'(proj_rst), 32'h7);
        wb_access(1'b1, 32'd1, rd);
        check("pin_wr_busy", 32'(busy), 32'd0);
        wb_access(1'b0, 32'd0, rd);
        check("pin_wr_readback", rd, 32'h4000_0003);
`else
        repeat (20) @(negedge clk);
        check("pin_ignored_cfg", 32'(cfg), 32'd0);
        check("pin_ignored_busy", 32'(busy), 32'd0);
        wb_access(1'b1, 32'd1, rd);
        check("pin_ignored_wr_cfg", 32'(cfg), 32'd1);
`endif
        pin_override = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
